fx_arb: RTL and testbench
=========================

# fx_arb

Two-master arbiter for the slave FPGA's fx configuration bus. It sits between the bus masters and the shared fx bus strobes that fan out to every module. Master 0 is the 485 command decoder; master 1 is a local configuration sequencer. The block grants the bus round-robin, runs exactly one write or read per grant, and returns read data via the fx_q return path with a fixed, parameterised latency.

## Interface
Parameters:
- RD_LAT, 2, cycles from the fx_rd strobe cycle to the cycle in which fx_q is valid; legal 1..7.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  transaction request; held until the matching gnt.
- m0_wr, m1_wr  in  1  1 = write, 0 = read; sampled with req.
- m0_addr, m1_addr  in  16  fx address; sampled with req.
- m0_data, m1_data  in  8  write data; sampled with req.
- m0_lock, m1_lock  in  1  keep ownership after done; effective only with FX_ARB_LOCK_EN.
- m0_gnt, m1_gnt  out  1  one-cycle pulse: the request is accepted.
- m0_done, m1_done  out  1  one-cycle pulse: the transaction is complete.
- m0_q, m1_q  out  8  read data; valid while done is high and held afterwards.
- fx_waddr  out  16  bus write address.
- fx_wr  out  1  one-cycle write strobe.
- fx_data  out  8  bus write data.
- fx_rd  out  1  one-cycle read strobe.
- fx_raddr  out  16  bus read address.
- fx_q  in  8  merged read return from the fx_bus mux.

## Operation
- States: IDLE, WR, RD, RWAIT, DONE.
- IDLE: if any eligible req is high, pick a winner and latch its wr, addr and data.
  - Go to WR if wr is 1, otherwise go to RD.
  - Eligible means both masters, unless a lock is held (see Configuration).
- Round-robin: rr_last records the last granted master. With both requesting, the other master wins. After reset rr_last = 1, so m0 wins first.
- WR:
  - For 1 cycle: assert the winner's gnt and fx_wr; drive fx_waddr/fx_data from the latches.
  - Go to DONE.
- RD:
  - For 1 cycle: assert gnt and fx_rd; drive fx_raddr from the latch.
  - Load a 3-bit counter with RD_LAT and go to RWAIT.
- RWAIT:
  - Decrement the counter each cycle.
  - When it reaches 1, register fx_q into the winner's m*_q and go to DONE.
  - RD_LAT=1 passes through RWAIT for exactly one cycle.
- DONE:
  - For 1 cycle: pulse the winner's done and update rr_last. For writes, m*_q keeps its previous value.
  - Return to IDLE.
- A req still high in the DONE cycle is treated as a new transaction in IDLE.
- Ports are never driven by the losing master: its gnt, done and q are untouched.
- fx_waddr, fx_raddr and fx_data hold their last value between transactions. The address and data latches update only in IDLE on a grant decision.
- fx_wr and fx_rd are never high in the same cycle. At most one transaction is outstanding.

## Timing
- Reset values: all gnt, done and strobes = 0; m*_q = 0; fx_waddr, fx_raddr and fx_data = 0; state IDLE; rr_last = 1; lock owner = none.
- Taking req seen high in IDLE at cycle t:
  - Write: gnt and fx_wr at t+1, done at t+2. The next grant decision can happen at t+3.
  - Read: gnt and fx_rd at t+1, fx_q sampled at t+1+RD_LAT, done and q at t+2+RD_LAT.
- Masters hold req/wr/addr/data stable from assertion through gnt, and drop req in the cycle after gnt unless issuing another transaction.
- rst asserted mid-transaction: the next cycle is the reset state. No done is issued, and an in-flight read return is discarded.
- Simultaneous req from both masters with no lock: grants alternate m0, m1, m0, …

## Configuration
- Macro FX_ARB_LOCK_EN.
- Defined:
  - If the granted master's lock is high in its DONE cycle, it becomes lock owner. Only its req is eligible in IDLE until it completes a transaction with lock low.
  - rr_last updates only when ownership is released.
- Undefined: m*_lock are ignored and no ownership state exists. Ports are present in both builds.

## Test plan
- Single write: m0 writes 0x1102 = 0xA5 → fx_wr is high one cycle with fx_waddr=0x1102 and fx_data=0xA5; m0_gnt at t+1, m0_done at t+2.
- Single read, RD_LAT=2: m1 reads 0x0204 and the bench drives fx_q=0x3C at t+3 → m1_done at t+4 with m1_q=0x3C; fx_rd high only at t+1.
- Contention: both masters request continuously from reset → grant order m0, m1, m0, m1; no gnt overlap and no strobe overlap.
- Lock (FX_ARB_LOCK_EN): m1 issues three writes with lock=1, 1, 0 while m0 requests → m0 is granted only after m1's third done. Without the macro, grants alternate.
- Reset mid-read: assert rst during RWAIT → no done pulse; all outputs at reset values next cycle; a subsequent m0 read completes normally.
- RD_LAT=1 sweep: reads with fx_q changing every cycle → m*_q equals fx_q from exactly the cycle after fx_rd.

Source files
------------

// File: rtl/fx_arb.sv
// fx_arb: round-robin arbiter giving two masters one fx bus transaction per grant; FX_ARB_LOCK_EN adds master lock.
// Latency: write gnt+fx_wr at t+1 and done at t+2; read gnt+fx_rd at t+1, fx_q sampled at t+1+RD_LAT, done at t+2+RD_LAT.
// Backpressure: one transaction in flight; the other master's req simply waits, held until its gnt.
module fx_arb #(
  parameter int RD_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_data,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [7:0]  m0_q,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_data,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [7:0]  m1_q,
  output logic [15:0] fx_waddr,
  output logic        fx_wr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [15:0] fx_raddr,
  input  logic [7:0]  fx_q
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  logic [2:0]  state_q, state_d;
  logic        win_q, win_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rr_last_q, rr_last_d;
  logic [7:0]  m0_rdat_q, m0_rdat_d;
  logic [7:0]  m1_rdat_q, m1_rdat_d;
  logic        elig0, elig1, pick;

`ifdef FX_ARB_LOCK_EN
  logic lock_vld_q, lock_vld_d;
  logic lock_own_q, lock_own_d;
  logic win_lock;

  // While a lock is held only the owner may compete for the bus.
  assign elig0    = m0_req && (!lock_vld_q || !lock_own_q);
  assign elig1    = m1_req && (!lock_vld_q ||  lock_own_q);
  assign win_lock = win_q ? m1_lock : m0_lock;
`else
  logic unused_lock;

  assign unused_lock = m0_lock ^ m1_lock;
  assign elig0       = m0_req;
  assign elig1       = m1_req;
`endif

  // Tie goes to the master that was not served last; otherwise the lone requester wins.
  assign pick = (elig0 && elig1) ? ~rr_last_q : elig1;

  // Transaction sequencer: grant decision, strobe phase, read wait, completion.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    m0_rdat_d = m0_rdat_q;
    m1_rdat_d = m1_rdat_q;
`ifdef FX_ARB_LOCK_EN
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (elig0 || elig1) begin
          win_d   = pick;
          addr_d  = pick ? m1_addr : m0_addr;
          data_d  = pick ? m1_data : m0_data;
          state_d = (pick ? m1_wr : m0_wr) ? S_WR : S_RD;
        end
      end
      S_WR: state_d = S_DONE;
      S_RD: begin
        cnt_d   = RD_LAT_C;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (cnt_q == 3'd1) begin
          if (win_q) m1_rdat_d = fx_q;
          else       m0_rdat_d = fx_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef FX_ARB_LOCK_EN
        // Round-robin history moves only when the bus is actually handed back.
        if (win_lock) begin
          lock_vld_d = 1'b1;
          lock_own_d = win_q;
        end else begin
          lock_vld_d = 1'b0;
          rr_last_d  = win_q;
        end
`else
        rr_last_d = win_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      addr_q    <= 16'h0000;
      data_q    <= 8'h00;
      cnt_q     <= 3'd0;
      rr_last_q <= 1'b1;
      m0_rdat_q <= 8'h00;
      m1_rdat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      m0_rdat_q <= m0_rdat_d;
      m1_rdat_q <= m1_rdat_d;
    end
  end

`ifdef FX_ARB_LOCK_EN
  // Lock ownership registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  // Strobes and handshakes decode straight from state; one address latch feeds both buses.
  assign fx_wr    = (state_q == S_WR);
  assign fx_rd    = (state_q == S_RD);
  assign fx_waddr = addr_q;
  assign fx_raddr = addr_q;
  assign fx_data  = data_q;
  assign m0_gnt   = (fx_wr || fx_rd) && !win_q;
  assign m1_gnt   = (fx_wr || fx_rd) &&  win_q;
  assign m0_done  = (state_q == S_DONE) && !win_q;
  assign m1_done  = (state_q == S_DONE) &&  win_q;
  assign m0_q     = m0_rdat_q;
  assign m1_q     = m1_rdat_q;

endmodule

// File: tb/tb_fx_arb.sv
// tb_fx_arb: scenario tasks for fx_arb with a queue of expected transactions per scenario.
// A second instance built with RD_LAT=1 shares the inputs and is examined only in the latency sweep.
// Every wait on the DUT is bounded by a cycle budget.
module tb_fx_arb;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_data, m1_data, fx_q;
  logic        m0_gnt, m0_done, m1_gnt, m1_done, fx_wr, fx_rd;
  logic [7:0]  m0_q, m1_q, fx_data;
  logic [15:0] fx_waddr, fx_raddr;
  logic        d1_m0_gnt, d1_m0_done, d1_m1_gnt, d1_m1_done, d1_fx_wr, d1_fx_rd;
  logic [7:0]  d1_m0_q, d1_m1_q, d1_fx_data;
  logic [15:0] d1_fx_waddr, d1_fx_raddr;

  typedef struct packed {
    logic        mst;
    logic [15:0] addr;
    logic [7:0]  dat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] qsb[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  fx_arb #(.RD_LAT(RD_LAT)) u_dut (
    .clk_sys(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_data(m0_data), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_q(m0_q),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_data(m1_data), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_q(m1_q),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data), .fx_rd(fx_rd), .fx_raddr(fx_raddr),
    .fx_q(fx_q)
  );

  fx_arb #(.RD_LAT(1)) u_dut1 (
    .clk_sys(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_data(m0_data), .m0_lock(m0_lock),
    .m0_gnt(d1_m0_gnt), .m0_done(d1_m0_done), .m0_q(d1_m0_q),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_data(m1_data), .m1_lock(m1_lock),
    .m1_gnt(d1_m1_gnt), .m1_done(d1_m1_done), .m1_q(d1_m1_q),
    .fx_waddr(d1_fx_waddr), .fx_wr(d1_fx_wr), .fx_data(d1_fx_data), .fx_rd(d1_fx_rd),
    .fx_raddr(d1_fx_raddr), .fx_q(fx_q)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0; m0_data = 8'h0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 16'h0; m1_data = 8'h0; m1_lock = 1'b0;
    fx_q = 8'h00;
    tick;
    tick;
    total++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, fx_wr, fx_rd} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {m0_gnt, m1_gnt, m0_done, m1_done, fx_wr, fx_rd});
    end
    total++;
    if ({m0_q, m1_q} !== 16'h0) begin
      bad++;
      $display("FAIL reset_q got=%h want=0000", {m0_q, m1_q});
    end
    total++;
    if ({fx_waddr, fx_raddr, fx_data} !== 40'h0) begin
      bad++;
      $display("FAIL reset_bus got=%h want=0", {fx_waddr, fx_raddr, fx_data});
    end
    total++;
    if ({d1_m0_gnt, d1_m1_gnt, d1_fx_wr, d1_fx_rd, d1_m0_q} !== 12'h0) begin
      bad++;
      $display("FAIL reset_lat1 got=%h want=0", {d1_m0_gnt, d1_m1_gnt, d1_fx_wr, d1_fx_rd, d1_m0_q});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    exp_t e;
    sb.push_back(exp_t'{mst: 1'b0, addr: 16'h1102, dat: 8'hA5});
    m0_wr = 1'b1; m0_addr = 16'h1102; m0_data = 8'hA5; m0_req = 1'b1;
    tick;  // t+1
    e = sb.pop_front();
    total++;
    if ({m0_gnt, m1_gnt, fx_wr, fx_rd} !== 4'b1010) begin
      bad++;
      $display("FAIL wr_gnt got=%b want=1010", {m0_gnt, m1_gnt, fx_wr, fx_rd});
    end
    total++;
    if ({fx_waddr, fx_data} !== {e.addr, e.dat}) begin
      bad++;
      $display("FAIL wr_bus got=%h/%h want=%h/%h", fx_waddr, fx_data, e.addr, e.dat);
    end
    m0_req = 1'b0;
    tick;  // t+2
    total++;
    if ({m0_done, m1_done, m0_gnt, fx_wr} !== 4'b1000) begin
      bad++;
      $display("FAIL wr_done got=%b want=1000", {m0_done, m1_done, m0_gnt, fx_wr});
    end
    total++;
    if (m0_q !== 8'h00) begin
      bad++;
      $display("FAIL wr_q_keep got=%h want=00", m0_q);
    end
    tick;  // t+3
    total++;
    if ({m0_done, fx_wr, fx_waddr, fx_data} !== {1'b0, 1'b0, e.addr, e.dat}) begin
      bad++;
      $display("FAIL wr_hold got=%b%b %h %h want=00 %h %h", m0_done, fx_wr, fx_waddr, fx_data, e.addr, e.dat);
    end
  endtask

  task automatic test_single_read;
    logic [7:0] want;
    qsb.push_back(8'h3C);
    m1_wr = 1'b0; m1_addr = 16'h0204; m1_data = 8'h00; m1_req = 1'b1;
    fx_q = 8'hFF;
    tick;  // t+1
    total++;
    if ({m0_gnt, m1_gnt, fx_rd, fx_wr} !== 4'b0110 || fx_raddr !== 16'h0204) begin
      bad++;
      $display("FAIL rd_gnt got=%b addr=%h want=0110 addr=0204", {m0_gnt, m1_gnt, fx_rd, fx_wr}, fx_raddr);
    end
    m1_req = 1'b0;
    for (int c = 2; c <= RD_LAT + 2; c++) begin
      tick;  // t+c
      fx_q = (c == RD_LAT + 1) ? 8'h3C : 8'hE0;
      total++;
      if (fx_rd !== 1'b0 || m1_done !== 1'(c == RD_LAT + 2)) begin
        bad++;
        $display("FAIL rd_timing cycle=t+%0d fx_rd=%b m1_done=%b want fx_rd=0 m1_done=%b",
                 c, fx_rd, m1_done, c == RD_LAT + 2);
      end
    end
    want = qsb.pop_front();
    total++;
    if (m1_q !== want || m0_done !== 1'b0) begin
      bad++;
      $display("FAIL rd_data got=%h m0_done=%b want=%h m0_done=0", m1_q, m0_done, want);
    end
    tick;
    total++;
    if (m1_q !== want || m1_done !== 1'b0) begin
      bad++;
      $display("FAIL rd_hold got=%h done=%b want=%h done=0", m1_q, m1_done, want);
    end
  endtask

  task automatic test_contention;
    exp_t e;
    int   grants = 0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.mst  = i[0];
      e.addr = i[0] ? 16'h00B1 : 16'h00A0;
      e.dat  = i[0] ? 8'h02 : 8'h01;
      sb.push_back(e);
    end
    m0_wr = 1'b1; m0_addr = 16'h00A0; m0_data = 8'h01; m0_req = 1'b1;
    m1_wr = 1'b1; m1_addr = 16'h00B1; m1_data = 8'h02; m1_req = 1'b1;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      tick;
      total++;
      if ((m0_gnt && m1_gnt) || (fx_wr && fx_rd)) begin
        bad++;
        $display("FAIL rr_overlap gnt=%b%b strobes=%b%b want no overlap", m0_gnt, m1_gnt, fx_wr, fx_rd);
      end
      if (m0_gnt || m1_gnt) begin
        e = sb.pop_front();
        total++;
        if ({m0_gnt, m1_gnt, fx_waddr, fx_data} !== {~e.mst, e.mst, e.addr, e.dat}) begin
          bad++;
          $display("FAIL rr_order grant=%0d got gnt=%b%b addr=%h want gnt=%b%b addr=%h",
                   grants, m0_gnt, m1_gnt, fx_waddr, ~e.mst, e.mst, e.addr);
        end
        grants++;
      end
    end
    total++;
    if (grants != 4) begin
      bad++;
      $display("FAIL rr_timeout got=%0d grants want=4", grants);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    sb.delete();
    tick; tick; tick;
  endtask

  task automatic test_lock;
    exp_t e;
    int   grants = 0;
    int   m1n = 0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
`ifdef FX_ARB_LOCK_EN
    e.mst = 1'b1; sb.push_back(e); sb.push_back(e); sb.push_back(e);
    e.mst = 1'b0; sb.push_back(e);
`else
    e.mst = 1'b1; sb.push_back(e);
    e.mst = 1'b0; sb.push_back(e);
    e.mst = 1'b1; sb.push_back(e); sb.push_back(e);
`endif
    m0_wr = 1'b1; m0_addr = 16'h00D0; m0_data = 8'h20; m0_req = 1'b0; m0_lock = 1'b0;
    m1_wr = 1'b1; m1_addr = 16'h00C0; m1_data = 8'h10; m1_lock = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 80 && grants < 4; c++) begin
      tick;
      if (m0_gnt || m1_gnt) begin
        e = sb.pop_front();
        total++;
        if ({m0_gnt, m1_gnt} !== {~e.mst, e.mst}) begin
          bad++;
          $display("FAIL lock_order grant=%0d got=%b%b want=%b%b", grants, m0_gnt, m1_gnt, ~e.mst, e.mst);
        end
        grants++;
        if (m1_gnt) begin
          m1n++;
          m1_lock = (m1n < 3);
          if (m1n == 1) m0_req = 1'b1;
          if (m1n == 3) m1_req = 1'b0;
        end else begin
          m0_req = 1'b0;
        end
      end
    end
    total++;
    if (grants != 4) begin
      bad++;
      $display("FAIL lock_timeout got=%0d grants want=4", grants);
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    sb.delete();
    tick; tick; tick;
  endtask

  task automatic test_reset_mid_read;
    int   seen = 0;
    int   lat = 0;
    logic [7:0] want;
    m0_wr = 1'b0; m0_addr = 16'h3344; m0_req = 1'b1;
    fx_q = 8'h99;
    tick;  // gnt
    m0_req = 1'b0;
    tick;  // first RWAIT cycle
    rst = 1'b1;
    tick;
    total++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, fx_wr, fx_rd} !== 6'b0 || {m0_q, m1_q} !== 16'h0 ||
        {fx_waddr, fx_raddr, fx_data} !== 40'h0) begin
      bad++;
      $display("FAIL mid_rst_state ctl=%b q=%h bus=%h want all zero",
               {m0_gnt, m1_gnt, m0_done, m1_done, fx_wr, fx_rd}, {m0_q, m1_q}, {fx_waddr, fx_raddr, fx_data});
    end
    rst = 1'b0;
    for (int c = 0; c < RD_LAT + 3; c++) begin
      tick;
      if (m0_done || m1_done) seen++;
    end
    total++;
    if (seen != 0 || m0_q !== 8'h00) begin
      bad++;
      $display("FAIL mid_rst_nodone got dones=%0d q=%h want dones=0 q=00", seen, m0_q);
    end
    qsb.push_back(8'hC3);
    fx_q = 8'hC3;
    m0_addr = 16'h0010; m0_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (m0_gnt) m0_req = 1'b0;
      if (m0_done) begin
        lat = c;
        break;
      end
    end
    want = qsb.pop_front();
    total++;
    if (lat != RD_LAT + 2 || m0_q !== want) begin
      bad++;
      $display("FAIL mid_rst_recover got lat=%0d q=%h want lat=%0d q=%h", lat, m0_q, RD_LAT + 2, want);
    end
    m0_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_rdlat1_sweep;
    int   dones = 0;
    logic rd_prev = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    qsb.delete();
    fx_q = 8'h07;
    m0_wr = 1'b0; m0_addr = 16'h0400; m0_req = 1'b1;
    for (int c = 0; c < 60 && dones < 4; c++) begin
      tick;
      fx_q = fx_q + 8'h35;
      if (rd_prev) qsb.push_back(fx_q);
      if (d1_m0_done) begin
        total++;
        if (qsb.size() == 0) begin
          bad++;
          $display("FAIL lat1_data got done with no read outstanding q=%h", d1_m0_q);
        end else if (d1_m0_q !== qsb[0]) begin
          bad++;
          $display("FAIL lat1_data read=%0d got=%h want=%h", dones, d1_m0_q, qsb[0]);
        end
        if (qsb.size() != 0) void'(qsb.pop_front());
        dones++;
      end
      rd_prev = d1_fx_rd;
    end
    total++;
    if (dones != 4) begin
      bad++;
      $display("FAIL lat1_timeout got=%0d dones want=4", dones);
    end
    m0_req = 1'b0;
    tick; tick; tick; tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_contention;
    test_lock;
    test_reset_mid_read;
    test_rdlat1_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
